// File: rtl/reg_writeback_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_pkg
//   Shared types and constants for the register-file write-back slice.
//   - REG_IDX_W : width of an architectural register index
//   - REG_X0    : index of the hard-wired zero register
//   - wbreq_t   : a completed result (destination + value) awaiting write-back
//   - port_e    : identifies the result port that last won arbitration
// ---------------------------------------------------------------------------
package reg_writeback_pkg;

  localparam int REG_IDX_W = 5;
  localparam int WB_XLEN   = 32;

  localparam logic [REG_IDX_W-1:0] REG_X0 = {REG_IDX_W{1'b0}};

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wbreq_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // True when the index names the zero register, which is never written.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] rd);
    return (rd == REG_X0);
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_if
//   One result channel (valid/ready handshake) from a producer unit to the
//   write-back block. A transfer happens on a cycle where valid && ready.
//   Signals:
//     valid : producer has a completed result (held stable until accepted)
//     rd    : destination register index
//     data  : result value
//     ready : write-back accepts the result this cycle
//   Modports: master = producer side, slave = write-back side.
// ---------------------------------------------------------------------------
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int XLEN = 32
);

  logic                 valid;
  logic [REG_IDX_W-1:0] rd;
  logic [XLEN-1:0]      data;
  logic                 ready;

  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);

endinterface

// File: rtl/reg_writeback_rr_arb2.sv
// ---------------------------------------------------------------------------
// reg_writeback_rr_arb2
//   Two-way round-robin arbiter. A single requester is always granted; when
//   both request, the one not granted last wins. The last-grant flop only
//   moves on a real grant and resets to B so that A wins the first tie.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset
//     req[1:0]  : requests, bit 0 = port A, bit 1 = port B
//     gnt[1:0]  : one-hot grant (combinational from req and last-grant)
// ---------------------------------------------------------------------------
module reg_writeback_rr_arb2
  import reg_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_r;

  // Grant selection: lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_r == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Last-grant history, updated only when a grant is actually given.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_r <= PORT_B;
    end else if (gnt[1]) begin
      last_r <= PORT_B;
    end else if (gnt[0]) begin
      last_r <= PORT_A;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//   Write side of the register file. Arbitrates completed results from the
//   execution unit (port a) and the memory unit (port b) onto the single,
//   registered regf write port, and keeps a per-register pending scoreboard
//   that decode queries for RAW/WAW stalls.
//   Ports:
//     clk, rstn          : clock, asynchronous active-low reset
//     issue_valid/rd     : decode issues an instruction that will write rd
//     issue_ready        : issue accepted (no WAW conflict on rd)
//     q_rs1, q_rs2       : decode source-operand queries
//     hazard             : a queried source has a pending write
//     a, b               : result channels (exec, mem), slave side
//     w_enable/addr/data : registered regf write port
// ---------------------------------------------------------------------------
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] q_rs1,
  input  logic [REG_IDX_W-1:0] q_rs2,
  output logic                 hazard,
  reg_writeback_if.slave       a,
  reg_writeback_if.slave       b,
  output logic                 w_enable,
  output logic [REG_IDX_W-1:0] w_addr,
  output logic [XLEN-1:0]      w_data
);

  logic [1:0]           req_s;
  logic [1:0]           gnt_s;
  wbreq_t               sel_s;
  logic                 wr_fire_s;
  logic                 issue_ready_s;
  logic                 issue_fire_s;
  logic                 hazard_s;
  logic [NREG-1:0]      busy_r;
  logic [NREG-1:0]      busy_nxt_s;
  logic                 w_enable_r;
  logic [REG_IDX_W-1:0] w_addr_r;
  logic [XLEN-1:0]      w_data_r;

  assign req_s = {b.valid, a.valid};

  reg_writeback_rr_arb2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_s),
    .gnt  (gnt_s)
  );

  assign a.ready = gnt_s[0];
  assign b.ready = gnt_s[1];

  // Result mux: forward the granted port's destination and value.
  always_comb begin
    sel_s = '{rd: a.rd, data: a.data};
    if (gnt_s[1]) begin
      sel_s = '{rd: b.rd, data: b.data};
    end else begin
      sel_s = '{rd: a.rd, data: a.data};
    end
  end

  // A granted result to x0 is consumed but never reaches regf.
  assign wr_fire_s = (|gnt_s) && !is_x0(sel_s.rd);

  // WAW check on issue; x0 never stalls.
  always_comb begin
    issue_ready_s = 1'b1;
    if (issue_valid && !is_x0(issue_rd)) begin
      issue_ready_s = ~busy_r[issue_rd];
    end else begin
      issue_ready_s = 1'b1;
    end
  end

  assign issue_fire_s = issue_valid && issue_ready_s && !is_x0(issue_rd);

  // RAW check for decode source operands.
  always_comb begin
    hazard_s = 1'b0;
    if ((!is_x0(q_rs1) && busy_r[q_rs1]) || (!is_x0(q_rs2) && busy_r[q_rs2])) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Scoreboard next state. A pending bit clears only after its regf write
  // cycle; issue of that same rd is refused while the bit is still set, so
  // the set and clear can never target one register on the same edge.
  always_comb begin
    busy_nxt_s = busy_r;
    if (w_enable_r) begin
      busy_nxt_s[w_addr_r] = 1'b0;
    end else begin
      busy_nxt_s[w_addr_r] = busy_r[w_addr_r];
    end
    if (issue_fire_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // regf write port register; address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_enable_r <= 1'b0;
      w_addr_r   <= REG_X0;
      w_data_r   <= {XLEN{1'b0}};
    end else begin
      w_enable_r <= wr_fire_s;
      if (wr_fire_s) begin
        w_addr_r <= sel_s.rd;
        w_data_r <= sel_s.data;
      end
    end
  end

  assign issue_ready = issue_ready_s;
  assign hazard      = hazard_s;
  assign w_enable    = w_enable_r;
  assign w_addr      = w_addr_r;
  assign w_data      = w_data_r;

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
//   Self-checking bench for reg_writeback. A reference model, evaluated on
//   each falling clock edge, predicts grants, issue_ready and hazard for the
//   current inputs and pushes the expected regf write for the next cycle
//   onto a scoreboard queue, which is popped and compared one cycle later.
//   Directed sequences add explicit checks; a random phase follows.
// ---------------------------------------------------------------------------
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_ready;
  logic [REG_IDX_W-1:0] q_rs1;
  logic [REG_IDX_W-1:0] q_rs2;
  logic                 hazard;
  logic                 w_enable;
  logic [REG_IDX_W-1:0] w_addr;
  logic [XLEN-1:0]      w_data;

  reg_writeback_if #(.XLEN(XLEN)) a_if ();
  reg_writeback_if #(.XLEN(XLEN)) b_if ();

  reg_writeback #(.XLEN(XLEN), .NREG(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .hazard      (hazard),
    .a           (a_if),
    .b           (b_if),
    .w_enable    (w_enable),
    .w_addr      (w_addr),
    .w_data      (w_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic                 we;
    logic [REG_IDX_W-1:0] addr;
    logic [XLEN-1:0]      data;
  } wexp_t;

  wexp_t exp_q[$];

  // Reference model and scoreboard
  initial begin
    logic [31:0]          m_busy;
    logic                 m_last_b;
    logic [REG_IDX_W-1:0] m_addr;
    logic [XLEN-1:0]      m_data;
    wexp_t                cur;
    wexp_t                nxt;
    logic                 ga, gb, ir, hz;
    logic [REG_IDX_W-1:0] rd_sel;
    logic [XLEN-1:0]      d_sel;
    m_busy = 32'd0; m_last_b = 1'b1; m_addr = 5'd0; m_data = 32'd0;
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 32'd0; m_last_b = 1'b1; m_addr = 5'd0; m_data = 32'd0;
        exp_q.delete();
        exp_q.push_back('{1'b0, 5'd0, 32'd0});
      end else begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
          cur = '{1'b0, m_addr, m_data};
        end else begin
          cur = exp_q.pop_front();
        end
        chk("w_enable", {63'd0, w_enable}, {63'd0, cur.we});
        chk("w_addr", {59'd0, w_addr}, {59'd0, cur.addr});
        chk("w_data", {32'd0, w_data}, {32'd0, cur.data});
        ga = a_if.valid && (!b_if.valid || m_last_b);
        gb = b_if.valid && !ga;
        chk("a_ready", {63'd0, a_if.ready}, {63'd0, ga});
        chk("b_ready", {63'd0, b_if.ready}, {63'd0, gb});
        ir = !issue_valid || (issue_rd == 5'd0) || !m_busy[issue_rd];
        chk("issue_ready", {63'd0, issue_ready}, {63'd0, ir});
        hz = ((q_rs1 != 5'd0) && m_busy[q_rs1]) || ((q_rs2 != 5'd0) && m_busy[q_rs2]);
        chk("hazard", {63'd0, hazard}, {63'd0, hz});
        rd_sel = gb ? b_if.rd : a_if.rd;
        d_sel  = gb ? b_if.data : a_if.data;
        nxt.we = (ga || gb) && (rd_sel != 5'd0);
        if (nxt.we) begin
          m_addr = rd_sel;
          m_data = d_sel;
        end
        nxt.addr = m_addr;
        nxt.data = m_data;
        exp_q.push_back(nxt);
        if (cur.we) m_busy[cur.addr] = 1'b0;
        if (issue_valid && ir && (issue_rd != 5'd0)) m_busy[issue_rd] = 1'b1;
        if (gb) m_last_b = 1'b1;
        else if (ga) m_last_b = 1'b0;
      end
    end
  end

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic a_acc;
    logic b_acc;
    a_if.valid = 1'b0; a_if.rd = 5'd0; a_if.data = 32'd0;
    b_if.valid = 1'b0; b_if.rd = 5'd0; b_if.data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_w_enable", {63'd0, w_enable}, 64'd0);
    chk("rst_w_addr", {59'd0, w_addr}, 64'd0);
    chk("rst_w_data", {32'd0, w_data}, 64'd0);

    // 1: A only
    cyc(); a_if.valid = 1'b1; a_if.rd = 5'd5; a_if.data = 32'hDEAD_BEEF;
    @(negedge clk); chk("t1_a_ready", {63'd0, a_if.ready}, 64'd1);
    cyc(); a_if.valid = 1'b0;
    @(negedge clk);
    chk("t1_we", {63'd0, w_enable}, 64'd1);
    chk("t1_addr", {59'd0, w_addr}, 64'd5);
    chk("t1_data", {32'd0, w_data}, 64'hDEAD_BEEF);

    // 4: result to x0 (on B, so B becomes last granted)
    cyc(); b_if.valid = 1'b1; b_if.rd = 5'd0; b_if.data = 32'd1; q_rs1 = 5'd0;
    @(negedge clk);
    chk("t4_b_ready", {63'd0, b_if.ready}, 64'd1);
    chk("t4_hazard", {63'd0, hazard}, 64'd0);
    cyc(); b_if.valid = 1'b0;
    @(negedge clk); chk("t4_we", {63'd0, w_enable}, 64'd0);

    // 2: both valid, round-robin A,B,A,B
    cyc(); a_if.valid = 1'b1; a_if.rd = 5'd1; a_if.data = 32'h11;
    b_if.valid = 1'b1; b_if.rd = 5'd2; b_if.data = 32'h22;
    @(negedge clk);
    chk("t2_g1_a", {63'd0, a_if.ready}, 64'd1);
    chk("t2_g1_b", {63'd0, b_if.ready}, 64'd0);
    cyc(); a_if.data = 32'h33;
    @(negedge clk);
    chk("t2_w1", {27'd0, w_addr, w_data}, {27'd0, 5'd1, 32'h11});
    chk("t2_g2_b", {63'd0, b_if.ready}, 64'd1);
    cyc(); b_if.data = 32'h44;
    @(negedge clk);
    chk("t2_w2", {27'd0, w_addr, w_data}, {27'd0, 5'd2, 32'h22});
    chk("t2_g3_a", {63'd0, a_if.ready}, 64'd1);
    cyc(); a_if.valid = 1'b0;
    @(negedge clk);
    chk("t2_w3", {27'd0, w_addr, w_data}, {27'd0, 5'd1, 32'h33});
    chk("t2_g4_b", {63'd0, b_if.ready}, 64'd1);
    cyc(); b_if.valid = 1'b0;
    @(negedge clk); chk("t2_w4", {27'd0, w_addr, w_data}, {27'd0, 5'd2, 32'h44});

    // 3: scoreboard set/clear around a write to x7
    cyc(); issue_valid = 1'b1; issue_rd = 5'd7; q_rs1 = 5'd7;
    @(negedge clk);
    chk("t3_iss_rdy", {63'd0, issue_ready}, 64'd1);
    chk("t3_hz0", {63'd0, hazard}, 64'd0);
    cyc();
    @(negedge clk);
    chk("t3_hz1", {63'd0, hazard}, 64'd1);
    chk("t3_waw", {63'd0, issue_ready}, 64'd0);
    cyc(); issue_valid = 1'b0; b_if.valid = 1'b1; b_if.rd = 5'd7; b_if.data = 32'h77;
    @(negedge clk); chk("t3_hz_acc", {63'd0, hazard}, 64'd1);
    cyc(); b_if.valid = 1'b0; issue_valid = 1'b1;
    @(negedge clk);
    chk("t3_we", {63'd0, w_enable}, 64'd1);
    chk("t3_hz_wcyc", {63'd0, hazard}, 64'd1);
    chk("t3_same_edge", {63'd0, issue_ready}, 64'd0);
    cyc();
    @(negedge clk);
    chk("t3_hz_after", {63'd0, hazard}, 64'd0);
    chk("t3_reissue", {63'd0, issue_ready}, 64'd1);
    cyc(); issue_valid = 1'b0;

    // 5: asynchronous reset during a write cycle
    cyc(); issue_valid = 1'b1; issue_rd = 5'd3; q_rs1 = 5'd3;
    cyc(); issue_valid = 1'b0; a_if.valid = 1'b1; a_if.rd = 5'd3; a_if.data = 32'h5;
    cyc(); a_if.valid = 1'b0;
    #1;
    chk("t5_pre_we", {63'd0, w_enable}, 64'd1);
    chk("t5_pre_hz", {63'd0, hazard}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_we", {63'd0, w_enable}, 64'd0);
    chk("t5_rst_hz", {63'd0, hazard}, 64'd0);
    rstn = 1'b1;
    cyc(); a_if.valid = 1'b1; a_if.rd = 5'd10; a_if.data = 32'h1;
    b_if.valid = 1'b1; b_if.rd = 5'd11; b_if.data = 32'h2;
    @(negedge clk);
    chk("t5_tie_a", {63'd0, a_if.ready}, 64'd1);
    chk("t5_tie_b", {63'd0, b_if.ready}, 64'd0);
    cyc(); a_if.valid = 1'b0;
    cyc(); b_if.valid = 1'b0;

    // 6: random traffic against the model
    a_acc = 1'b0;
    b_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!a_if.valid || a_acc) begin
        a_if.valid = 1'($urandom_range(0, 1));
        a_if.rd    = 5'($urandom_range(0, 15));
        a_if.data  = $urandom;
      end
      if (!b_if.valid || b_acc) begin
        b_if.valid = 1'($urandom_range(0, 1));
        b_if.rd    = 5'($urandom_range(0, 15));
        b_if.data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 15));
      q_rs1       = 5'($urandom_range(0, 15));
      q_rs2       = 5'($urandom_range(0, 15));
      @(negedge clk);
      a_acc = a_if.valid && a_if.ready;
      b_acc = b_if.valid && b_if.ready;
    end
    cyc();
    a_if.valid = 1'b0; b_if.valid = 1'b0; issue_valid = 1'b0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
